// File: rtl/game_state_ctrl_if.sv
// Signal bundle between the game-flow sequencer and its surroundings.
// No valid/ready handshake here: inputs are single-cycle pulses or levels sampled on every clk edge.
interface game_state_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic       collision;
    logic       pause;
    logic [3:0] state;
    logic       state_chg;
    logic [7:0] elapsed_sec;
    logic [7:0] best_sec;
    logic       paused;

    modport master (
        output frame_tick, start, collision, pause,
        input  state, state_chg, elapsed_sec, best_sec, paused
    );

    modport slave (
        input  frame_tick, start, collision, pause,
        output state, state_chg, elapsed_sec, best_sec, paused
    );
endinterface

// File: rtl/game_state_ctrl.sv
// Game-flow sequencer: GAMESTART/EASY/NORMAL/HARD/INFERNO/FAILURE, committed on frame ticks.
// Optional pause support is enabled by defining PAUSE_EN.
module game_state_ctrl #(
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned NORMAL_AT      = 15,
    parameter int unsigned HARD_AT        = 30,
    parameter int unsigned INFERNO_AT     = 45
) (
    input logic             clk,
    input logic             rst,
    game_state_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        S_GAMESTART = 4'd0,
        S_EASY      = 4'd1,
        S_NORMAL    = 4'd2,
        S_HARD      = 4'd3,
        S_INFERNO   = 4'd4,
        S_FAILURE   = 4'd5
    } state_t;

    localparam logic [7:0] FPS_M1     = 8'(FRAMES_PER_SEC - 1);
    localparam logic [7:0] NORMAL_8   = 8'(NORMAL_AT);
    localparam logic [7:0] HARD_8     = 8'(HARD_AT);
    localparam logic [7:0] INFERNO_8  = 8'(INFERNO_AT);

    state_t     state_q, state_d;
    logic [7:0] frame_q, frame_d;
    logic [7:0] elapsed_q, elapsed_d;
    logic [7:0] best_q, best_d;
    logic       start_pend_q, start_pend_d;
    logic       hit_pend_q, hit_pend_d;
    logic       paused_q, paused_d;
    logic       chg_q;
    logic       in_play, in_idle, next_in_play, advance, pause_req;
    logic [7:0] elapsed_inc;

`ifdef PAUSE_EN
    assign pause_req = bus.pause;
`else
    logic pause_unused;
    assign pause_unused = bus.pause;
    assign pause_req    = 1'b0;
`endif

    assign in_play      = (state_q >= S_EASY) && (state_q <= S_INFERNO);
    assign in_idle      = (state_q == S_GAMESTART) || (state_q == S_FAILURE);
    assign next_in_play = (state_d >= S_EASY) && (state_d <= S_INFERNO);
    // paused_q can only be set in play states, so it gates nothing elsewhere
    assign advance      = bus.frame_tick & ~paused_q;
    assign elapsed_inc  = (elapsed_q == 8'd255) ? 8'd255 : elapsed_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        elapsed_d    = elapsed_q;
        best_d       = best_q;
        paused_d     = paused_q;
        start_pend_d = start_pend_q | (bus.start & in_idle);
        hit_pend_d   = hit_pend_q | (bus.collision & in_play & ~paused_q);

        case (state_q)
            S_GAMESTART: begin
                if (advance && start_pend_d) begin
                    state_d      = S_EASY;
                    frame_d      = 8'd0;
                    elapsed_d    = 8'd0;
                    start_pend_d = 1'b0;
                end
            end
            S_EASY, S_NORMAL, S_HARD, S_INFERNO: begin
                if (advance) begin
                    if (hit_pend_d) begin
                        state_d    = S_FAILURE;
                        hit_pend_d = 1'b0;
                        paused_d   = 1'b0;
                        if (elapsed_q > best_q) best_d = elapsed_q;
                    end else begin
                        if (frame_q == FPS_M1) begin
                            frame_d   = 8'd0;
                            elapsed_d = elapsed_inc;
                        end else begin
                            frame_d = frame_q + 8'd1;
                        end
                        // promotion looks at the elapsed value being committed this tick
                        if (state_q == S_EASY && elapsed_d >= NORMAL_8)
                            state_d = S_NORMAL;
                        else if (state_q == S_NORMAL && elapsed_d >= HARD_8)
                            state_d = S_HARD;
                        else if (state_q == S_HARD && elapsed_d >= INFERNO_8)
                            state_d = S_INFERNO;
                    end
                end
            end
            S_FAILURE: begin
                if (advance && start_pend_d) begin
                    state_d      = S_GAMESTART;
                    start_pend_d = 1'b0;
                end
            end
            default: begin
                state_d      = S_GAMESTART;
                start_pend_d = 1'b0;
                hit_pend_d   = 1'b0;
                paused_d     = 1'b0;
            end
        endcase

        if (pause_req && in_play && next_in_play) begin
            paused_d = ~paused_q;
            if (!paused_q) hit_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_GAMESTART;
            frame_q      <= 8'd0;
            elapsed_q    <= 8'd0;
            best_q       <= 8'd0;
            start_pend_q <= 1'b0;
            hit_pend_q   <= 1'b0;
            paused_q     <= 1'b0;
            chg_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            elapsed_q    <= elapsed_d;
            best_q       <= best_d;
            start_pend_q <= start_pend_d;
            hit_pend_q   <= hit_pend_d;
            paused_q     <= paused_d;
            chg_q        <= (state_d != state_q);
        end
    end

    assign bus.state       = state_q;
    assign bus.state_chg   = chg_q;
    assign bus.elapsed_sec = elapsed_q;
    assign bus.best_sec    = best_q;
    assign bus.paused      = paused_q;
endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed scenarios plus random stimulus against a reference model.
module tb_game_state_ctrl;
    localparam int FPS  = 4;
    localparam int N_AT = 2;
    localparam int H_AT = 4;
    localparam int I_AT = 6;
`ifdef PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    game_state_ctrl_if bus();

    game_state_ctrl #(
        .FRAMES_PER_SEC(FPS),
        .NORMAL_AT(N_AT),
        .HARD_AT(H_AT),
        .INFERNO_AT(I_AT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: a run is summarised by frames played since EASY entry
    int   m_state, m_frames, m_best;
    bit   m_spend, m_hpend, m_paused;
    logic [21:0] exp_q[$];

    function automatic int m_elapsed();
        int e;
        e = m_frames / FPS;
        return (e > 255) ? 255 : e;
    endfunction

    function automatic int level_for(input int el);
        if (el >= I_AT) return 4;
        if (el >= H_AT) return 3;
        if (el >= N_AT) return 2;
        return 1;
    endfunction

    function automatic logic [21:0] pack(input int s, input bit chg, input int el, input int best, input bit p);
        return {4'(s), chg, 8'(el), 8'(best), p};
    endfunction

    task automatic model_step();
        int s_n;
        bit play, spend_n, hit_eff;
        play    = (m_state >= 1 && m_state <= 4);
        s_n     = m_state;
        spend_n = m_spend | (bus.start && (m_state == 0 || m_state == 5));
        hit_eff = m_hpend | (bus.collision && play && !m_paused);
        m_spend = spend_n;
        m_hpend = play ? hit_eff : 1'b0;
        if (bus.frame_tick && !m_paused) begin
            if (m_state == 0 && spend_n) begin
                s_n = 1; m_frames = 0; m_spend = 0;
            end else if (m_state == 5 && spend_n) begin
                s_n = 0; m_spend = 0;
            end else if (play) begin
                if (hit_eff) begin
                    s_n = 5; m_hpend = 0; m_paused = 0;
                    if (m_elapsed() > m_best) m_best = m_elapsed();
                end else begin
                    m_frames++;
                    if (level_for(m_elapsed()) > m_state) s_n = m_state + 1;
                end
            end
        end
        if (PAUSE_ON && bus.pause && play && s_n >= 1 && s_n <= 4) begin
            if (!m_paused) m_hpend = 0;
            m_paused = !m_paused;
        end
        exp_q.push_back(pack(s_n, s_n != m_state, m_elapsed(), m_best, m_paused));
        m_state = s_n;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_frames = 0; m_best = 0;
            m_spend = 0; m_hpend = 0; m_paused = 0;
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    // scoreboard: every cycle out of reset
    always @(negedge clk) begin
        logic [21:0] e, g;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {bus.state, bus.state_chg, bus.elapsed_sec, bus.best_sec, bus.paused};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t got state=%0d chg=%0b el=%0d best=%0d paused=%0b exp state=%0d chg=%0b el=%0d best=%0d paused=%0b",
                         $time, g[21:18], g[17], g[16:9], g[8:1], g[0], e[21:18], e[17], e[16:9], e[8:1], e[0]);
            end
        end
    end

    // driver tasks
    task automatic step(input bit ft, input bit st, input bit col, input bit pz);
        bus.frame_tick = ft;
        bus.start      = st;
        bus.collision  = col;
        bus.pause      = pz;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
        end
    endtask

    task automatic restart();
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    initial begin
        bus.frame_tick = 0; bus.start = 0; bus.collision = 0; bus.pause = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_state", bus.state, 0);
        check("rst_chg", bus.state_chg, 0);
        check("rst_elapsed", bus.elapsed_sec, 0);
        check("rst_best", bus.best_sec, 0);
        check("rst_paused", bus.paused, 0);

        // first run: start then tick
        restart();
        check("enter_easy_state", bus.state, 1);
        check("enter_easy_chg", bus.state_chg, 1);
        check("enter_easy_el", bus.elapsed_sec, 0);
        step(0, 0, 0, 0);
        check("chg_one_cycle", bus.state_chg, 0);

        // collision between ticks at 3 s
        ticks(12);
        check("el3_state", bus.state, 2);
        check("el3_el", bus.elapsed_sec, 3);
        step(0, 0, 1, 0);
        check("hit_waits_tick", bus.state, 2);
        step(1, 0, 0, 0);
        check("hit_state", bus.state, 5);
        check("hit_best", bus.best_sec, 3);
        restart();
        check("fail_to_start", bus.state, 0);
        restart();
        check("rerun_state", bus.state, 1);
        check("rerun_el", bus.elapsed_sec, 0);
        check("rerun_best", bus.best_sec, 3);

        // fail in HARD at 4 s
        ticks(16);
        check("hard_state", bus.state, 3);
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        check("best4", bus.best_sec, 4);
        restart(); restart();

        // collision on the tick that would promote NORMAL->HARD
        ticks(15);
        check("pre_hard_state", bus.state, 2);
        step(1, 0, 1, 0);
        check("coinc_state", bus.state, 5);
        check("coinc_best", bus.best_sec, 4);
        check("coinc_el", bus.elapsed_sec, 3);
        restart(); restart();

        // promotion ladder and INFERNO terminal
        ticks(8);
        check("ladder_normal", bus.state, 2);
        check("ladder_el2", bus.elapsed_sec, 2);
        ticks(16);
        check("ladder_inferno", bus.state, 4);
        check("ladder_el6", bus.elapsed_sec, 6);
        ticks(8);
        check("inferno_hold", bus.state, 4);
        step(1, 0, 1, 0);
        check("inferno_best", bus.best_sec, 8);
        restart(); restart();

        // async reset mid-HARD, start+tick discarded while rst is high
        ticks(16);
        check("pre_rst_hard", bus.state, 3);
        #2 rst = 1;
        #1;
        check("arst_state", bus.state, 0);
        check("arst_el", bus.elapsed_sec, 0);
        check("arst_best", bus.best_sec, 0);
        bus.frame_tick = 1; bus.start = 1;
        @(posedge clk);
        #1 rst = 0;
        step(0, 0, 0, 0);
        check("post_rst_idle", bus.state, 0);
        ticks(3);
        check("post_rst_ticks", bus.state, 0);
        restart();
        check("post_rst_start", bus.state, 1);

`ifdef PAUSE_EN
        ticks(4);
        step(0, 0, 0, 1);
        check("pause_set", bus.paused, 1);
        repeat (20) begin
            step(1, 0, 1, 0);
            step(0, 0, 1, 0);
        end
        check("paused_state", bus.state, 1);
        check("paused_el", bus.elapsed_sec, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        check("pause_clr", bus.paused, 0);
        ticks(4);
        check("resume_el", bus.elapsed_sec, 2);
        check("resume_state", bus.state, 2);
`else
        step(0, 0, 0, 1);
        check("pause_ignored", bus.paused, 0);
`endif

        // random phase
        repeat (4000) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 29) == 0);
        end
        step(0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
